// File: rtl/ysyx_040978_mdu_ctrl.sv
// Issue/retire controller between the execute-stage decoder and the multiply/divide unit.
// Optional YSYX_040978_MDU_FASTPATH_EN resolves divide-by-zero and signed overflow locally.
module ysyx_040978_mdu_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic            mdu_mul,
  output logic            mdu_mulh,
  output logic            mdu_mulhu,
  output logic            mdu_mulhsu,
  output logic            mdu_div,
  output logic            mdu_divu,
  output logic            mdu_rem,
  output logic            mdu_remu,
  output logic [XLEN-1:0] mdu_src1,
  output logic [XLEN-1:0] mdu_src2,
  input  logic [XLEN-1:0] mdu_result,
  input  logic            mdu_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  logic            word_div;
  logic [2:0]      op_sel;
  logic [XLEN-1:0] prep1, prep2;
  logic [XLEN-1:0] unit_adj;
  logic            fast_hit;
  logic [XLEN-1:0] fast_raw, fast_adj;

  // Word divides extend the low half; word multiplies of any flavour collapse onto mul.
  assign word_div = in_word & in_funct3[2];
  assign op_sel   = (in_word & ~in_funct3[2]) ? 3'd0 : in_funct3;
  assign prep1    = !word_div ? in_src1 :
                    in_funct3[0] ? {{(XLEN-32){1'b0}}, in_src1[31:0]}
                                 : {{(XLEN-32){in_src1[31]}}, in_src1[31:0]};
  assign prep2    = !word_div ? in_src2 :
                    in_funct3[0] ? {{(XLEN-32){1'b0}}, in_src2[31:0]}
                                 : {{(XLEN-32){in_src2[31]}}, in_src2[31:0]};
  assign unit_adj = word_q ? {{(XLEN-32){mdu_result[31]}}, mdu_result[31:0]} : mdu_result;

`ifdef YSYX_040978_MDU_FASTPATH_EN
  logic div_zero, min_dividend, ovf;
  assign div_zero     = (prep2 == '0);
  assign min_dividend = in_word ? (prep1 == {{(XLEN-31){1'b1}}, 31'b0})
                                : (prep1 == {1'b1, {(XLEN-1){1'b0}}});
  assign ovf          = ~in_funct3[0] & min_dividend & (prep2 == '1);
  assign fast_hit     = in_funct3[2] & (div_zero | ovf);
  // funct3[1] selects remainder over quotient
  assign fast_raw     = div_zero ? (in_funct3[1] ? prep1 : '1)
                                 : (in_funct3[1] ? '0 : prep1);
`else
  assign fast_hit     = 1'b0;
  assign fast_raw     = '0;
`endif
  assign fast_adj = in_word ? {{(XLEN-32){fast_raw[31]}}, fast_raw[31:0]} : fast_raw;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          word_d = in_word;
          rd_d   = in_rd;
          src1_d = prep1;
          src2_d = prep2;
          if (fast_hit) begin
            result_d = fast_adj;
            state_d  = StDone;
          end else begin
            op_d    = 8'b0000_0001 << op_sel;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          if (mdu_ready) begin
            op_d    = '0;
            state_d = StIdle;
          end else begin
            state_d = StDrain;
          end
        end else if (mdu_ready) begin
          op_d     = '0;
          result_d = unit_adj;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (flush || out_ready) state_d = StIdle;
      end
      StDrain: begin
        // Strobe stays up until the unit finishes so it cannot relaunch the stale op.
        if (mdu_ready) begin
          op_d    = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      word_q   <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_rd     = rd_q;
  assign mdu_src1   = src1_q;
  assign mdu_src2   = src2_q;
  assign mdu_mul    = op_q[0];
  assign mdu_mulh   = op_q[1];
  assign mdu_mulhsu = op_q[2];
  assign mdu_mulhu  = op_q[3];
  assign mdu_div    = op_q[4];
  assign mdu_divu   = op_q[5];
  assign mdu_rem    = op_q[6];
  assign mdu_remu   = op_q[7];

endmodule

// File: tb/tb_ysyx_040978_mdu_ctrl.sv
// Bench for ysyx_040978_mdu_ctrl: directed vectors, flush/reset corners and random ops
// checked against an RV64M instruction-level model driving a behavioural unit.
module tb_ysyx_040978_mdu_ctrl;

`ifdef YSYX_040978_MDU_FASTPATH_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = '0, in_src2 = '0;
  logic [4:0]  in_rd = '0;
  logic        mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu, mdu_div, mdu_divu, mdu_rem, mdu_remu;
  logic [63:0] mdu_src1, mdu_src2;
  logic [63:0] mdu_result = '0;
  logic        mdu_ready = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic [7:0]  strobes;

  int n_chk = 0;
  int n_fail = 0;
  int lat = 1;
  int mock_cnt = 0;

  always #5 clock = ~clock;

  ysyx_040978_mdu_ctrl #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .mdu_mul(mdu_mul), .mdu_mulh(mdu_mulh), .mdu_mulhu(mdu_mulhu), .mdu_mulhsu(mdu_mulhsu),
    .mdu_div(mdu_div), .mdu_divu(mdu_divu), .mdu_rem(mdu_rem), .mdu_remu(mdu_remu),
    .mdu_src1(mdu_src1), .mdu_src2(mdu_src2), .mdu_result(mdu_result), .mdu_ready(mdu_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd)
  );

  assign strobes = {mdu_remu, mdu_rem, mdu_divu, mdu_div, mdu_mulhu, mdu_mulhsu, mdu_mulh, mdu_mul};

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RV64M architectural result of one instruction.
  function automatic logic [63:0] isa_ref(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ps;
    logic [127:0]        pu;
    logic signed [63:0]  sa, sb;
    logic [63:0]         ua, ub, mn, r;
    sa = w ? sx32(a[31:0]) : a;
    sb = w ? sx32(b[31:0]) : b;
    ua = w ? {32'b0, a[31:0]} : a;
    ub = w ? {32'b0, b[31:0]} : b;
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    r  = '0;
    if (w && !f3[2]) r = a * b;
    else begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
        3'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = ps[127:64]; end
        3'd3: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
        3'd4: begin
          if (sb == 0) r = '1;
          else if (sa == mn && sb == '1) r = sa;
          else r = sa / sb;
        end
        3'd5: begin
          if (ub == 0) r = '1;
          else r = ua / ub;
        end
        3'd6: begin
          if (sb == 0) r = sa;
          else if (sa == mn && sb == '1) r = '0;
          else r = sa % sb;
        end
        default: begin
          if (ub == 0) r = ua;
          else r = ua % ub;
        end
      endcase
    end
    return w ? sx32(r[31:0]) : r;
  endfunction

  function automatic logic [63:0] prep(input logic [2:0] f3, input logic w, input logic [63:0] x);
    if (w && f3[2]) return f3[0] ? {32'b0, x[31:0]} : sx32(x[31:0]);
    return x;
  endfunction

  function automatic bit fast_case(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf  = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    return Fast && f3[2] && (zero || ovf);
  endfunction

  function automatic logic [2:0] op_of(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Behavioural unit: ready when idle, completes `lat` cycles after the strobe rises.
  always @(negedge clock) begin
    if (strobes != 8'h0) begin
      mock_cnt++;
      mdu_ready  = (mock_cnt >= lat);
      mdu_result = isa_ref(op_of(strobes), 1'b0, mdu_src1, mdu_src2);
    end else begin
      mock_cnt   = 0;
      mdu_ready  = 1'b1;
      mdu_result = 64'hDEAD_BEEF_0BAD_F00D;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input int l, input int hold,
                        input logic [63:0] exp_s1, input logic [63:0] exp_s2,
                        input logic [63:0] exp_res, input bit fast);
    int cyc;
    logic [7:0] exp_stb;
    lat = l;
    cyc = 0;
    while (!in_ready && cyc < 200) begin step(); cyc++; end
    chk("accept_ready", in_ready, 1);
    in_funct3 = f3; in_word = w; in_src1 = a; in_src2 = b; in_rd = rd; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
    exp_stb = (w && !f3[2]) ? 8'h01 : (8'h01 << f3);
    cyc = 1;
    if (fast) chk("fast_no_strobe", strobes, 0);
    while (!out_valid && cyc < 200) begin
      chk("busy_strobe", strobes, exp_stb);
      chk("busy_src1", mdu_src1, exp_s1);
      chk("busy_src2", mdu_src2, exp_s2);
      chk("busy_in_ready", in_ready, 0);
      step();
      cyc++;
    end
    chk("out_valid_seen", out_valid, 1);
    chk("latency", cyc, fast ? 1 : l + 1);
    chk("result", out_result, exp_res);
    chk("rd", out_rd, rd);
    chk("done_strobe_low", strobes, 0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, exp_res);
      chk("hold_rd", out_rd, rd);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_strobe", strobes, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("retire_valid_low", out_valid, 0);
    chk("retire_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    logic [4:0]  rd;
    int          l;
    logic [63:0] s1, s2, res;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 1,
                64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[1]  = '{3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 5'd2, 3,
                64'hFFFF_FFFF_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000};
    tbl[2]  = '{3'd5, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 5'd3, 2,
                64'h0000_0000_8000_0000, 64'd2, 64'h0000_0000_4000_0000};
    tbl[3]  = '{3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd4, 4,
                64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4]  = '{3'd1, 1'b1, 64'h0000_0001_0000_0003, 64'h10, 5'd5, 2,
                64'h0000_0001_0000_0003, 64'h10, 64'h30};
    tbl[5]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
    tbl[6]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd7, 5,
                64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[7]  = '{3'd7, 1'b1, 64'hFFFF_FFFF_0000_0009, 64'h0000_0005_0000_0004, 5'd8, 1,
                64'd9, 64'd4, 64'd1};
    tbl[8]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9, 2,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[9]  = '{3'd5, 1'b0, 64'd100, 64'd7, 5'd10, 3, 64'd100, 64'd7, 64'd14};
    tbl[10] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd11, 1,
                64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};

    #2 reset = 1'b0;
    step();
    step();
    chk("rst_strobes", strobes, 0);
    chk("rst_src1", mdu_src1, 0);
    chk("rst_src2", mdu_src2, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    step();

    foreach (tbl[i])
      run_op(tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].l, i % 3,
             tbl[i].s1, tbl[i].s2, tbl[i].res, 1'b0);

    // Division special cases: resolved locally when the fast path is built in.
    run_op(3'd4, 1'b0, 64'd7, 64'd0, 5'd12, 2, 0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, Fast);
    run_op(3'd7, 1'b0, 64'd7, 64'd0, 5'd13, 2, 0, 64'd7, 64'd0, 64'd7, Fast);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 2, 0,
           64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, Fast);
    run_op(3'd6, 1'b1, 64'h0000_0001_8000_0005, 64'hFFFF_0000_0000_0000, 5'd15, 1, 0,
           64'hFFFF_FFFF_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, Fast);
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 1, 0,
           64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, Fast);

    // Flush during a long divide: strobe held until the unit finishes, result dropped.
    lat = 64;
    in_funct3 = 3'd4; in_word = 1'b0; in_src1 = 64'd100; in_src2 = 64'd7; in_rd = 5'd17;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("drain_c1_div", mdu_div, 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 3; c <= 64; c++) begin
      chk("drain_div_high", mdu_div, 1);
      chk("drain_no_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 0);
      step();
    end
    chk("drain_div_low", mdu_div, 0);
    chk("drain_idle", in_ready, 1);
    chk("drain_end_valid", out_valid, 0);
    step();
    chk("drain_after_valid", out_valid, 0);

    // Flush coinciding with unit completion.
    lat = 2;
    in_funct3 = 3'd0; in_src1 = 64'd5; in_src2 = 64'd6; in_rd = 5'd18; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushrdy_in_ready", in_ready, 1);
    chk("flushrdy_valid", out_valid, 0);
    chk("flushrdy_strobe", strobes, 0);
    step();
    chk("flushrdy_valid2", out_valid, 0);

    // Flush while the result waits for writeback.
    lat = 1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("flushdone_valid_pre", out_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushdone_valid", out_valid, 0);
    chk("flushdone_in_ready", in_ready, 1);

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flushidle_strobe", strobes, 0);
    chk("flushidle_in_ready", in_ready, 1);
    step();
    chk("flushidle_valid", out_valid, 0);

    run_op(3'd0, 1'b0, 64'd9, 64'd9, 5'd19, 1, 0, 64'd9, 64'd9, 64'd81, 1'b0);

    // Asynchronous reset in the middle of a busy op.
    lat = 10;
    in_funct3 = 3'd5; in_src1 = 64'd1000; in_src2 = 64'd3; in_rd = 5'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    chk("arst_strobes", strobes, 0);
    chk("arst_src1", mdu_src1, 0);
    chk("arst_src2", mdu_src2, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_rd", out_rd, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("arst_rel_in_ready", in_ready, 1);
    chk("arst_rel_strobes", strobes, 0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = rnd_opnd();
      b  = rnd_opnd();
      run_op(f3, w, a, b, 5'($urandom_range(0, 31)), $urandom_range(1, 4), $urandom_range(0, 2),
             prep(f3, w, a), prep(f3, w, b), isa_ref(f3, w, a, b), fast_case(f3, w, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_040978_mdu_ctrl.md
# ysyx_040978_mdu_ctrl

Issue/retire controller between the execute-stage decoder and the multiply/divide unit. Takes one RV64M instruction (funct3, word flag, operands, rd) via valid/ready handshake. Prepares the unit's one-hot op strobes and operands, including 32-bit word-op extension, and holds them until the unit signals completion. Returns the final (word-adjusted) result to writeback via a valid/ready handshake.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 supported.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; kills the in-flight instruction.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_funct3  in  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- in_word  in  1  W-variant (mulw/divw/divuw/remw/remuw).
- in_src1, in_src2  in  64  rs1, rs2 values.
- in_rd  in  5  destination register tag.
- mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu, mdu_div, mdu_divu, mdu_rem, mdu_remu  out  1 each  one-hot op strobes to the unit.
- mdu_src1, mdu_src2  out  64  operands to the unit.
- mdu_result  in  64  unit result.
- mdu_ready  in  1  unit done; only meaningful while a strobe is high.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts.
- out_result  out  64  final rd value.
- out_rd  out  5  tag of the result.

## Operation
- States: IDLE, BUSY, DONE, DRAIN. Reset → IDLE. All registered outputs reset to 0: strobes 0, out_valid 0, out_result 0, out_rd 0, mdu_src* 0.
- in_ready = (state == IDLE).
- IDLE, in_valid & ~flush:
  - Register the op, word flag, rd, and operands.
  - Go to BUSY, or to DONE when the fast path applies.
- Operand prep (word ops):
  - divw/remw: sext(src[31:0]).
  - divuw/remuw: zext(src[31:0]).
  - mulw: operands passed unmodified.
  - in_word with funct3 001–011 is treated as mulw.
- BUSY:
  - Exactly one strobe high; operands held stable.
  - On mdu_ready: capture the result, clear the strobe in the next cycle, go to DONE.
- Result adjust (word ops): out_result = sext(mdu_result[31:0]). Otherwise out_result = mdu_result unmodified.
- DONE: out_valid = 1; out_result and out_rd held. On out_ready → IDLE.
- Flush handling:
  - flush in DONE → IDLE; the result is discarded.
  - flush in BUSY → DRAIN. DRAIN keeps the strobe high until mdu_ready, discards the result, then → IDLE. This stops the unit relaunching a stale op.
  - flush in IDLE blocks acceptance that cycle.
- Simultaneous flush and mdu_ready in BUSY: the result is discarded and the state goes to IDLE.

## Timing
- Acceptance at cycle 0. Strobe is high from cycle 1 through the cycle mdu_ready is seen (cycle k).
- Strobe is low at cycle k+1. out_valid is high from cycle k+1.
- Minimum latency, accept to out_valid: 2 cycles via the unit, 1 cycle via the fast path.
- Strobes are never high in IDLE or DONE. This guarantees the unit's ready-when-idle output is never mistaken for completion.
- Back-to-back: a new request is accepted in the cycle after the out_ready handshake, never in the same cycle.

## Configuration
- YSYX_040978_MDU_FASTPATH_EN defined: division special cases resolve in the controller. The op goes straight to DONE in cycle 1 with no strobe issued.
  - Divide by zero: div/divu quotient = all ones; rem/remu = dividend (word: sext of the 32-bit prepared dividend).
  - Signed overflow (-2^63 / -1, word: -2^31 / -1): quotient = dividend; rem = 0.
- Undefined: all ops go to the unit; its result is returned unmodified, apart from the word adjustment for W-variants.

## Test plan
- mul, src1=3, src2=-5, unit returns after 1 cycle → out_result 0xFFFF_FFFF_FFFF_FFF1, out_valid at cycle 2; mdu_mul high only in cycle 1.
- divw, src1=0x0000_0001_8000_0000, src2=2 → mdu_src1 0xFFFF_FFFF_8000_0000; out_result 0xFFFF_FFFF_C000_0000.
- FASTPATH_EN: div by 0, src1=7 → quotient 0xFFFF_FFFF_FFFF_FFFF at cycle 1, no strobe. remu by 0 → 7. div 0x8000_0000_0000_0000 by -1 → 0x8000_0000_0000_0000.
- flush in cycle 2 of a 64-cycle divide → mdu_div stays high until mdu_ready, out_valid never asserts, in_ready returns the cycle after mdu_ready.
- out_ready held low 5 cycles → out_valid, out_result, and out_rd stable; in_ready low; strobes low.
- reset asserted low mid-BUSY → all outputs 0 immediately (asynchronous); after release, state is IDLE and in_ready = 1.
